// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/control unit.
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when an ID source operand is actually read and names the EX destination.
    function automatic logic src_match(input logic [4:0] rs,
                                       input logic       use_src,
                                       input logic [4:0] rd);
        return use_src && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Wrapping stall/flush performance counters with per-cycle increment enables.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_inc) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / taken-branch hazard detection and multi-cycle MULDIV sequencing for
// the 5-stage core; drives front-end freeze, flushes and EX hold.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    input  logic             USERS1_ID,
    input  logic             USERS2_ID,
    input  logic [4:0]       RD_EX,
    input  logic             MEMREAD_EX,
    input  logic             MULDIV_EX,
    input  logic             PCSRC_EX,
    output logic             stall,
    output logic             PCWRITE,
    output logic             IFID_WRITE,
    output logic             IFID_FLUSH,
    output logic             IDEX_FLUSH,
    output logic             EX_HOLD,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT,
    output hz_state_t        dbg_state
);

    // Keep the counter at least one bit wide so MD_LATENCY=1 still elaborates.
    localparam int MD_CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

    hz_state_t           state_q, state_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic                load_use;
    logic                flush_ev;

    assign load_use = MEMREAD_EX && (RD_EX != REG_ZERO) &&
                      (src_match(RS1_ID, USERS1_ID, RD_EX) ||
                       src_match(RS2_ID, USERS2_ID, RD_EX));

    always_comb begin
        state_d    = state_q;
        md_cnt_d   = md_cnt_q;
        stall      = 1'b0;
        IFID_FLUSH = 1'b0;
        IDEX_FLUSH = 1'b0;
        EX_HOLD    = 1'b0;
        flush_ev   = 1'b0;

        case (state_q)
            RUN: begin
                // A taken branch makes the ID instruction wrong-path, so it beats load_use.
                if (PCSRC_EX) begin
                    IFID_FLUSH = 1'b1;
                    IDEX_FLUSH = 1'b1;
                    flush_ev   = 1'b1;
                end else if (MULDIV_EX && (MD_LATENCY > 1)) begin
                    EX_HOLD  = 1'b1;
                    stall    = 1'b1;
                    state_d  = MD_BUSY;
                    md_cnt_d = MD_CNT_W'(MD_LATENCY - 2);
                end else if (load_use) begin
                    stall = 1'b1;
                end
            end
            MD_BUSY: begin
                // MULDIV_EX stays high through the final cycle; it is the same op, not a new one.
                if (md_cnt_q != '0) begin
                    EX_HOLD  = 1'b1;
                    stall    = 1'b1;
                    md_cnt_d = md_cnt_q - 1'b1;
                end else begin
                    stall   = load_use;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (!rst_n) begin
            state_d    = RUN;
            md_cnt_d   = '0;
            stall      = 1'b0;
            IFID_FLUSH = 1'b0;
            IDEX_FLUSH = 1'b0;
            EX_HOLD    = 1'b0;
            flush_ev   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    assign PCWRITE    = ~stall;
    assign IFID_WRITE = ~stall;
    assign dbg_state  = state_q;

    hazard_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall_inc(stall),
        .flush_inc(flush_ev),
        .stall_cnt(STALL_CNT),
        .flush_cnt(FLUSH_CNT)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, x0/unused sources, branch priority,
// MULDIV occupancy (latency 4 and 1), back-to-back ops and reset mid-op.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_id, rs2_id, rd_ex;
    logic        users1_id, users2_id, memread_ex, muldiv_ex, pcsrc_ex;

    logic        stall, pcwrite, ifid_write, ifid_flush, idex_flush, ex_hold;
    logic [31:0] stall_cnt, flush_cnt;
    hz_state_t   dbg_state;

    logic        stall1, pcwrite1, ifid_write1, ifid_flush1, idex_flush1, ex_hold1;
    logic [31:0] stall_cnt1, flush_cnt1;
    hz_state_t   dbg_state1;

    int n_checks = 0;
    int n_fails  = 0;

    hazard_ctrl #(.MD_LATENCY(4), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .RS1_ID(rs1_id), .RS2_ID(rs2_id), .USERS1_ID(users1_id), .USERS2_ID(users2_id),
        .RD_EX(rd_ex), .MEMREAD_EX(memread_ex), .MULDIV_EX(muldiv_ex), .PCSRC_EX(pcsrc_ex),
        .stall(stall), .PCWRITE(pcwrite), .IFID_WRITE(ifid_write),
        .IFID_FLUSH(ifid_flush), .IDEX_FLUSH(idex_flush), .EX_HOLD(ex_hold),
        .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt), .dbg_state(dbg_state)
    );

    hazard_ctrl #(.MD_LATENCY(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .RS1_ID(rs1_id), .RS2_ID(rs2_id), .USERS1_ID(users1_id), .USERS2_ID(users2_id),
        .RD_EX(rd_ex), .MEMREAD_EX(memread_ex), .MULDIV_EX(muldiv_ex), .PCSRC_EX(pcsrc_ex),
        .stall(stall1), .PCWRITE(pcwrite1), .IFID_WRITE(ifid_write1),
        .IFID_FLUSH(ifid_flush1), .IDEX_FLUSH(idex_flush1), .EX_HOLD(ex_hold1),
        .STALL_CNT(stall_cnt1), .FLUSH_CNT(flush_cnt1), .dbg_state(dbg_state1)
    );

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparison helper
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic e_stall, input logic e_flush,
                            input logic e_hold);
        chk({tag, ".stall"},      {31'd0, stall},      {31'd0, e_stall});
        chk({tag, ".pcwrite"},    {31'd0, pcwrite},    {31'd0, ~e_stall});
        chk({tag, ".ifid_write"}, {31'd0, ifid_write}, {31'd0, ~e_stall});
        chk({tag, ".ifid_flush"}, {31'd0, ifid_flush}, {31'd0, e_flush});
        chk({tag, ".idex_flush"}, {31'd0, idex_flush}, {31'd0, e_flush});
        chk({tag, ".ex_hold"},    {31'd0, ex_hold},    {31'd0, e_hold});
    endtask

    // Driver: apply a new input vector at the falling edge, settle 1 time unit.
    task automatic drive(input logic rst_v, input logic mr, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic md, input logic pc);
        @(negedge clk);
        rst_n      = rst_v;
        memread_ex = mr;
        rd_ex      = rd;
        rs1_id     = rs1;
        users1_id  = u1;
        rs2_id     = rs2;
        users2_id  = u2;
        muldiv_ex  = md;
        pcsrc_ex   = pc;
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] hold_pat;
        rst_n = 1'b0;
        {memread_ex, muldiv_ex, pcsrc_ex, users1_id, users2_id} = '0;
        {rd_ex, rs1_id, rs2_id} = '0;

        // Reset with a live load-use match: controls must be forced idle.
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_ctrl("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.stall_cnt", stall_cnt, 32'd0);
        chk("reset.flush_cnt", flush_cnt, 32'd0);
        chk("reset.state", 32'(dbg_state), 32'(RUN));

        // Load-use on rs1: one-cycle stall, then released.
        drive(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_ctrl("lu_rs1", 1'b1, 1'b0, 1'b0);
        idle();
        chk_ctrl("lu_after", 1'b0, 1'b0, 1'b0);
        chk("lu.stall_cnt", stall_cnt, 32'd1);

        // x0 destination never hazards.
        drive(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        chk_ctrl("x0", 1'b0, 1'b0, 1'b0);
        // rs2 matches but is unused.
        drive(1'b1, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        chk_ctrl("rs2_unused", 1'b0, 1'b0, 1'b0);
        // Matching register but EX is not a load.
        drive(1'b1, 1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        chk_ctrl("not_load", 1'b0, 1'b0, 1'b0);
        // rs2 used and matching.
        drive(1'b1, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        chk_ctrl("lu_rs2", 1'b1, 1'b0, 1'b0);

        // Taken branch over a load-use match: flush wins, no stall.
        drive(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        chk_ctrl("branch", 1'b0, 1'b1, 1'b0);
        idle();
        chk("branch.flush_cnt", flush_cnt, 32'd1);
        chk("branch.stall_cnt", stall_cnt, 32'd2);

        // Single MULDIV (latency 4): hold for t..t+2, release at t+3.
        hold_pat = 8'b1110_0000;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
            chk_ctrl($sformatf("md1[%0d]", i), hold_pat[7-i], 1'b0, hold_pat[7-i]);
            chk($sformatf("md1_lat1[%0d].stall", i), {31'd0, stall1}, 32'd0);
            chk($sformatf("md1_lat1[%0d].ex_hold", i), {31'd0, ex_hold1}, 32'd0);
        end
        idle();
        chk("md1.state", 32'(dbg_state), 32'(RUN));
        chk("md1.stall_cnt", stall_cnt, 32'd5);
        chk_ctrl("md1_after", 1'b0, 1'b0, 1'b0);

        // Back-to-back MULDIV: EX_HOLD 1,1,1,0,1,1,1,0.
        hold_pat = 8'b1110_1110;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            chk_ctrl($sformatf("md2[%0d]", i), hold_pat[7-i], 1'b0, hold_pat[7-i]);
        end
        idle();
        chk("md2.stall_cnt", stall_cnt, 32'd11);
        chk("md2.state", 32'(dbg_state), 32'(RUN));

        // Reset in the second cycle of a MULDIV abandons it.
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk_ctrl("rst_md_t0", 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk_ctrl("rst_md_t1", 1'b0, 1'b0, 1'b0);
        idle();
        chk("rst_md.state", 32'(dbg_state), 32'(RUN));
        chk_ctrl("rst_md_t2", 1'b0, 1'b0, 1'b0);
        chk("rst_md.stall_cnt", stall_cnt, 32'd0);
        chk("rst_md.flush_cnt", flush_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
